// File: rtl/rf_pkg.sv
// Shared defaults and bus-packing helpers for the multiport register file.
// Imported by the top and the pending-bit scoreboard.
package rf_pkg;

  localparam int RF_DATA_W  = 32;
  localparam int RF_ADDR_W  = 5;
  localparam int RF_NR_READ = 2;
  localparam int RF_DEPTH   = 2 ** RF_ADDR_W;

  localparam int RF_NR_READ_MIN = 1;
  localparam int RF_NR_READ_MAX = 4;

  localparam int RF_RD_ADDR_BUS_W = RF_NR_READ * RF_ADDR_W;
  localparam int RF_RD_DATA_BUS_W = RF_NR_READ * RF_DATA_W;

  // Low bit of port idx inside a flattened bus of w-bit lanes.
  function automatic int port_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set on issue, cleared on writeback.
// Set beats clear on the same address; bypassed reads hide pending.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NR_READ  = RF_NR_READ,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      set,
  input  logic [ADDR_W-1:0]         set_addr,
  input  logic                      clr,
  input  logic [ADDR_W-1:0]         clr_addr,
  input  logic [NR_READ*ADDR_W-1:0] rd_addr,
  output logic [NR_READ-1:0]        rd_pending,
  output logic                      any_pending
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;
  logic             set_ok;

  always_comb begin
    set_ok      = set && !((ZERO_REG != 0) && (set_addr == '0));
    pending_nxt = pending;
    if (clr) begin
      pending_nxt[clr_addr] = 1'b0;
    end
    // A new producer overrides the one retiring this cycle.
    if (set_ok) begin
      pending_nxt[set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp;

    assign ra  = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];
    assign byp = (BYPASS != 0) && clr && (clr_addr == ra);

    assign rd_pending[i] = pending[ra] & ~byp;
  end

  assign any_pending = |pending;

endmodule

// File: rtl/rf_multiport_sb.sv
// Parametrised register file: N comb read ports, one write port,
// optional write bypass, hardwired zero reg and a pending scoreboard.
module rf_multiport_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NR_READ  = RF_NR_READ,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [NR_READ*ADDR_W-1:0] rd_addr,
  output logic [NR_READ*DATA_W-1:0] rd_data,
  input  logic                      pend_set,
  input  logic [ADDR_W-1:0]         pend_addr,
  output logic [NR_READ-1:0]        rd_pending,
  output logic                      any_pending
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (NR_READ < RF_NR_READ_MIN || NR_READ > RF_NR_READ_MAX) begin : g_chk
    $error("rf_multiport_sb: NR_READ must be 1..4");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              byp_ok;

  assign wr_ok  = we && !((ZERO_REG != 0) && (wr_addr == '0));
  assign byp_ok = wr_ok && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar i = 0; i < NR_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];

    always_comb begin
      rv = mem[ra];
      if (!rst_n) begin
        rv = '0;
      end else if ((ZERO_REG != 0) && (ra == '0)) begin
        rv = '0;
      end else if ((BYPASS != 0) && byp_ok && (wr_addr == ra)) begin
        rv = wr_data;
      end
    end

    assign rd_data[port_lo(i, DATA_W) +: DATA_W] = rv;
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NR_READ (NR_READ),
    .BYPASS  (BYPASS),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set        (pend_set),
    .set_addr   (pend_addr),
    .clr        (byp_ok),
    .clr_addr   (wr_addr),
    .rd_addr    (rd_addr),
    .rd_pending (rd_pending),
    .any_pending(any_pending)
  );

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Directed bench: a bypassing 3-port instance and a non-bypassing
// 2-port instance share the write/scoreboard stimulus.
module tb_rf_multiport_sb;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pend_set;
  logic [4:0]  pend_addr;

  logic [14:0] rd_addr3;
  logic [95:0] rd_data3;
  logic [2:0]  rd_pend3;
  logic        any3;

  logic [9:0]  rd_addr2;
  logic [63:0] rd_data2;
  logic [1:0]  rd_pend2;
  logic        any2;

  int n_chk;
  int n_fail;

  rf_multiport_sb #(
    .DATA_W(32), .ADDR_W(5), .NR_READ(3), .BYPASS(1), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr3), .rd_data(rd_data3),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .rd_pending(rd_pend3), .any_pending(any3)
  );

  rf_multiport_sb #(
    .DATA_W(32), .ADDR_W(5), .NR_READ(2), .BYPASS(0), .ZERO_REG(1)
  ) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .pend_set(pend_set), .pend_addr(pend_addr),
    .rd_pending(rd_pend2), .any_pending(any2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1,
                        input logic [4:0] a2);
    rd_addr3 = {a2, a1, a0};
    rd_addr2 = {a1, a0};
  endtask

  task automatic idle();
    we = 1'b0;
    pend_set = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wr_addr = a; wr_data = d;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (rd_data3 !== 96'h0 || rd_data2 !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_rd_data got %h/%h exp 0", rd_data3, rd_data2);
    end
    n_chk++;
    if (any3 !== 1'b0 || any2 !== 1'b0 || rd_pend3 !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_pending got %b%b%b exp 0", any3, any2, rd_pend3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    we = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    pend_set = 1'b1; pend_addr = 5'd7;
    step();
    idle();
    set_rd(5'd5, 5'd5, 5'd7);
    #1;
    n_chk++;
    if (rd_data3[31:0] !== 32'hDEADBEEF || rd_data2[31:0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL pre_reset_data got %h/%h exp deadbeef",
               rd_data3[31:0], rd_data2[31:0]);
    end
    n_chk++;
    if (any3 !== 1'b1 || rd_pend3 !== 3'b100) begin
      n_fail++;
      $display("FAIL pre_reset_pend got %b %b exp 1 100", any3, rd_pend3);
    end
    #1 rst_n = 1'b0;
    #1;
    n_chk++;
    if (rd_data3[31:0] !== 32'h0 || rd_data2[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_data got %h/%h exp 0",
               rd_data3[31:0], rd_data2[31:0]);
    end
    n_chk++;
    if (any3 !== 1'b0 || any2 !== 1'b0 || rd_pend3 !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset_pend got %b%b %b exp 0", any3, any2, rd_pend3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_zero();
    we = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    pend_set = 1'b1; pend_addr = 5'd0;
    set_rd(5'd0, 5'd0, 5'd0);
    #1;
    n_chk++;
    if (rd_data3 !== 96'h0 || rd_pend3 !== 3'b0) begin
      n_fail++;
      $display("FAIL zero_no_bypass got %h %b exp 0", rd_data3, rd_pend3);
    end
    step();
    idle();
    #1;
    n_chk++;
    if (rd_data3 !== 96'h0 || rd_data2 !== 64'h0) begin
      n_fail++;
      $display("FAIL zero_read got %h/%h exp 0", rd_data3, rd_data2);
    end
    n_chk++;
    if (any3 !== 1'b0 || any2 !== 1'b0 || rd_pend2 !== 2'b0) begin
      n_fail++;
      $display("FAIL zero_pend got %b%b %b exp 0", any3, any2, rd_pend2);
    end
  endtask

  task automatic test_bypass();
    wr(5'd3, 32'h0BADF00D);
    we = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    set_rd(5'd3, 5'd3, 5'd3);
    #1;
    n_chk++;
    if (rd_data3 !== {3{32'hA5A5A5A5}}) begin
      n_fail++;
      $display("FAIL bypass_on got %h exp a5a5a5a5 x3", rd_data3);
    end
    n_chk++;
    if (rd_data2 !== {2{32'h0BADF00D}}) begin
      n_fail++;
      $display("FAIL bypass_off_old got %h exp 0badf00d x2", rd_data2);
    end
    step();
    idle();
    #1;
    n_chk++;
    if (rd_data2 !== {2{32'hA5A5A5A5}} || rd_data3 !== {3{32'hA5A5A5A5}}) begin
      n_fail++;
      $display("FAIL bypass_stored got %h/%h exp a5a5a5a5", rd_data3, rd_data2);
    end
  endtask

  task automatic test_scoreboard();
    pend_set = 1'b1; pend_addr = 5'd9;
    set_rd(5'd9, 5'd9, 5'd9);
    #1;
    n_chk++;
    if (rd_pend3 !== 3'b000 || any3 !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_cycle0 got %b %b exp 000 0", rd_pend3, any3);
    end
    for (int c = 1; c <= 3; c++) begin
      step();
      pend_set = 1'b0;
      #1;
      n_chk++;
      if (rd_pend3 !== 3'b111 || rd_pend2 !== 2'b11 || any2 !== 1'b1) begin
        n_fail++;
        $display("FAIL sb_cycle%0d got %b %b %b exp 111 11 1",
                 c, rd_pend3, rd_pend2, any2);
      end
    end
    step();
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h55;
    #1;
    n_chk++;
    if (rd_pend3 !== 3'b000 || rd_pend2 !== 2'b11) begin
      n_fail++;
      $display("FAIL sb_cycle4 got %b %b exp 000 11", rd_pend3, rd_pend2);
    end
    n_chk++;
    if (any3 !== 1'b1 || rd_data3[31:0] !== 32'h55) begin
      n_fail++;
      $display("FAIL sb_cycle4_any got %b %h exp 1 55", any3, rd_data3[31:0]);
    end
    step();
    idle();
    #1;
    n_chk++;
    if (rd_pend2 !== 2'b00 || any3 !== 1'b0 || any2 !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_cycle5 got %b %b%b exp 00 00", rd_pend2, any3, any2);
    end
  endtask

  task automatic test_collision();
    pend_set = 1'b1; pend_addr = 5'd9;
    step();
    pend_set = 1'b1; pend_addr = 5'd9;
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h11;
    set_rd(5'd9, 5'd9, 5'd9);
    #1;
    n_chk++;
    if (rd_pend3 !== 3'b000 || rd_data3[63:32] !== 32'h11) begin
      n_fail++;
      $display("FAIL coll_same_cycle got %b %h exp 000 11",
               rd_pend3, rd_data3[63:32]);
    end
    step();
    idle();
    #1;
    n_chk++;
    if (rd_pend3 !== 3'b111 || rd_pend2 !== 2'b11 || any2 !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_set_wins got %b %b %b exp 111 11 1",
               rd_pend3, rd_pend2, any2);
    end
    n_chk++;
    if (rd_data3[31:0] !== 32'h11 || rd_data2[63:32] !== 32'h11) begin
      n_fail++;
      $display("FAIL coll_data got %h/%h exp 11",
               rd_data3[31:0], rd_data2[63:32]);
    end
    pend_set = 1'b1; pend_addr = 5'd4;
    we = 1'b1; wr_addr = 5'd9; wr_data = 32'h22;
    step();
    idle();
    set_rd(5'd9, 5'd4, 5'd9);
    #1;
    n_chk++;
    if (rd_pend3 !== 3'b010 || rd_pend2 !== 2'b10) begin
      n_fail++;
      $display("FAIL diff_addr got %b %b exp 010 10", rd_pend3, rd_pend2);
    end
    wr(5'd4, 32'h44);
    #1;
    n_chk++;
    if (any3 !== 1'b0 || any2 !== 1'b0) begin
      n_fail++;
      $display("FAIL drain got %b%b exp 00", any3, any2);
    end
  endtask

  task automatic test_extremes();
    wr(5'd31, 32'hFFFFFFFF);
    wr(5'd1, 32'h00000001);
    set_rd(5'd31, 5'd1, 5'd31);
    #1;
    n_chk++;
    if (rd_data3 !== 96'hFFFFFFFF_00000001_FFFFFFFF) begin
      n_fail++;
      $display("FAIL extremes3 got %h exp ffffffff_00000001_ffffffff",
               rd_data3);
    end
    n_chk++;
    if (rd_data2 !== 64'h00000001_FFFFFFFF) begin
      n_fail++;
      $display("FAIL extremes2 got %h exp 00000001_ffffffff", rd_data2);
    end
    set_rd(5'd0, 5'd30, 5'd5);
    #1;
    n_chk++;
    if (rd_data3 !== 96'h0 || rd_data2 !== 64'h0) begin
      n_fail++;
      $display("FAIL no_alias got %h/%h exp 0", rd_data3, rd_data2);
    end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; wr_addr = 5'd2; wr_data = 32'hCAFE0001;
    step();
    wr_data = 32'hCAFE0002;
    set_rd(5'd2, 5'd2, 5'd2);
    #1;
    n_chk++;
    if (rd_data3[31:0] !== 32'hCAFE0002 || rd_data2[31:0] !== 32'hCAFE0001) begin
      n_fail++;
      $display("FAIL b2b_mid got %h/%h exp cafe0002/cafe0001",
               rd_data3[31:0], rd_data2[31:0]);
    end
    step();
    idle();
    #1;
    n_chk++;
    if (rd_data2[63:32] !== 32'hCAFE0002) begin
      n_fail++;
      $display("FAIL b2b_final got %h exp cafe0002", rd_data2[63:32]);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    we = 1'b0; wr_addr = '0; wr_data = '0;
    pend_set = 1'b0; pend_addr = '0;
    set_rd(5'd0, 5'd0, 5'd0);
    #12;
    test_reset();
    test_zero();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_extremes();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
